// File: rtl/sm_addsub_pipe_if.sv
// Operand/result bundle for the sign-magnitude add/subtract pipeline.
// Ports: in_valid/in_ready + A/B operands + op (upstream beat),
//        out_valid/out_ready + res_mag/res_neg/res_zero/res_ovf (downstream result).
interface sm_addsub_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_mag;
  logic             a_neg;
  logic [WIDTH-1:0] b_mag;
  logic             b_neg;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   res_mag;
  logic             res_neg;
  logic             res_zero;
  logic             res_ovf;

  // Producer of operands / consumer of results (capture logic + display path).
  modport master (
    output in_valid, a_mag, a_neg, b_mag, b_neg, op, out_ready,
    input  in_ready, out_valid, res_mag, res_neg, res_zero, res_ovf
  );

  // The arithmetic unit itself.
  modport slave (
    input  in_valid, a_mag, a_neg, b_mag, b_neg, op, out_ready,
    output in_ready, out_valid, res_mag, res_neg, res_zero, res_ovf
  );
endinterface

// File: rtl/sm_addsub_pipe.sv
// Sign-magnitude A+B / A-B unit, 2-stage valid/ready pipeline, 2 cycles accept->out_valid.
// Ports: clk, Reset (sync, active-high), bus (sm_addsub_pipe_if.slave: operands in, result out).
// Option: define SM_ADDSUB_SAT_EN to clamp overflowing magnitudes to 2^WIDTH-1 (res_ovf still set).
module sm_addsub_pipe #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            Reset,
  sm_addsub_pipe_if.slave bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       s1_st;
  logic [0:0]       s2_st;
  logic             s1_valid;
  logic             s2_load;
  logic             accept;

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_a_neg;
  logic             s1_eb_neg;
  logic             s1_a_ge_b;

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   raw_mag;
  logic [WIDTH:0]   fin_mag;
  logic             raw_neg;
  logic             fin_neg;
  logic             fin_zero;
  logic             fin_ovf;

  logic [WIDTH:0]   res_mag;
  logic             res_neg;
  logic             res_zero;
  logic             res_ovf;

  assign s1_valid     = (s1_st == ST_FULL);
  assign bus.out_valid = (s2_st == ST_FULL);
  // S2 can take a new entry when it is empty or its current result leaves this cycle.
  assign s2_load      = (s2_st == ST_EMPTY) || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_load;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.res_mag  = res_mag;
  assign bus.res_neg  = res_neg;
  assign bus.res_zero = res_zero;
  assign bus.res_ovf  = res_ovf;

  // Stage 1: capture operands; subtraction is folded into B's effective sign.
  always_ff @(posedge clk) begin
    if (Reset) begin
      s1_st <= ST_EMPTY;
    end else if (accept) begin
      s1_st     <= ST_FULL;
      s1_a      <= bus.a_mag;
      s1_b      <= bus.b_mag;
      s1_a_neg  <= bus.a_neg;
      s1_eb_neg <= bus.b_neg ^ bus.op;
      s1_a_ge_b <= (bus.a_mag >= bus.b_mag);
    end else if (s2_load) begin
      s1_st <= ST_EMPTY;
    end
  end

  // Sign-magnitude arithmetic on the S1 contents.
  always_comb begin
    a_ext    = {1'b0, s1_a};
    b_ext    = {1'b0, s1_b};
    raw_mag  = '0;
    raw_neg  = 1'b0;
    if (s1_a_neg == s1_eb_neg) begin
      raw_mag = a_ext + b_ext;
      raw_neg = s1_a_neg;
    end else if (s1_a_ge_b) begin
      raw_mag = a_ext - b_ext;
      raw_neg = s1_a_neg;
    end else begin
      raw_mag = b_ext - a_ext;
      raw_neg = s1_eb_neg;
    end
    fin_ovf = raw_mag[WIDTH];
`ifdef SM_ADDSUB_SAT_EN
    fin_mag = fin_ovf ? {1'b0, {WIDTH{1'b1}}} : raw_mag;
`else
    fin_mag = raw_mag;
`endif
    fin_zero = (fin_mag == '0);
    // Equal magnitudes with opposite signs would otherwise yield -0.
    fin_neg  = raw_neg && !fin_zero;
  end

  // Stage 2: result registers drive the outputs directly and hold while stalled.
  always_ff @(posedge clk) begin
    if (Reset) begin
      s2_st    <= ST_EMPTY;
      res_mag  <= '0;
      res_neg  <= 1'b0;
      res_zero <= 1'b1;
      res_ovf  <= 1'b0;
    end else if (s2_load) begin
      s2_st <= s1_valid ? ST_FULL : ST_EMPTY;
      if (s1_valid) begin
        res_mag  <= fin_mag;
        res_neg  <= fin_neg;
        res_zero <= fin_zero;
        res_ovf  <= fin_ovf;
      end
    end
  end

endmodule
